fc_argmax_reader: RTL

//  Consumer end of the fully-connected layer's output interface. Accepts one Q16.16 score vector per

---
 rtl/fc_argmax_reader_pkg.sv | 34 +++
 rtl/fc_argmax_reader_cmp.sv | 36 +++
 rtl/fc_argmax_reader.sv | 117 +++++++++++
 3 files changed

// File: rtl/fc_argmax_reader_pkg.sv
// Shared constants, types and helpers for the FC-layer argmax reader.
// Optional score/margin outputs are enabled with FC_SCORE_OUT_EN.
package fc_pkg;

   localparam int unsigned BITWIDTH    = 32;
   localparam int unsigned FRAC_BITS   = 16;
   localparam int unsigned NUM_CLASSES = 10;
   localparam int unsigned IDX_W       = 4;

   typedef logic signed [BITWIDTH-1:0] score_t;
   typedef logic [NUM_CLASSES-1:0][BITWIDTH-1:0] score_vec_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } fc_rd_state_t;

   localparam score_t SCORE_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};
   localparam score_t SCORE_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};

   // best - second in one extra bit, clamped to the positive score range
   function automatic score_t sat_margin(input score_t best, input score_t second);
      logic [BITWIDTH:0] diff;
      diff = {best[BITWIDTH-1], best} - {second[BITWIDTH-1], second};
      if (diff[BITWIDTH])
         return '0;
      else if (diff[BITWIDTH-1])
         return SCORE_MAX;
      else
         return score_t'(diff[BITWIDTH-1:0]);
   endfunction

endpackage

// File: rtl/fc_argmax_reader_cmp.sv
// Single-step running-max update: folds one candidate score into (best, best_idx[, second]).
// The second-best path exists only with FC_SCORE_OUT_EN.
module fc_argmax_cmp
   import fc_pkg::*;
(
   input  score_t           cand,
   input  logic [IDX_W-1:0] idx,
   input  score_t           best,
   input  logic [IDX_W-1:0] best_idx,
`ifdef FC_SCORE_OUT_EN
   input  score_t           second,
   output score_t           second_c,
`endif
   output score_t           best_c,
   output logic [IDX_W-1:0] best_idx_c
);

   // Strict compare: on a tie the earlier index keeps the win
   always_comb begin
      best_c     = best;
      best_idx_c = best_idx;
`ifdef FC_SCORE_OUT_EN
      second_c   = second;
`endif
      if (cand > best) begin
         best_c     = cand;
         best_idx_c = idx;
`ifdef FC_SCORE_OUT_EN
         second_c   = best;
      end else if (cand > second) begin
         second_c   = cand;
`endif
      end
   end

endmodule

// File: rtl/fc_argmax_reader.sv
// Argmax consumer for the FC layer: buffers one score vector, scans it one element per clock
// and returns the winning class index. FC_SCORE_OUT_EN adds winning score and margin outputs.
module fc_argmax_reader
   import fc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  score_vec_t       in_vector,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_class,
   output logic             busy
`ifdef FC_SCORE_OUT_EN
   ,
   output score_t           out_score,
   output score_t           out_margin
`endif
);

   fc_rd_state_t     state, state_nx;
   score_t           buffer [NUM_CLASSES];
   score_t           best, best_c;
   logic [IDX_W-1:0] best_idx, best_idx_c;
   logic [IDX_W-1:0] idx;
   logic             last_c;
`ifdef FC_SCORE_OUT_EN
   score_t           second, second_c;
`endif

   assign last_c = (idx == IDX_W'(NUM_CLASSES - 1));

   fc_argmax_cmp u_cmp (
      .cand       (buffer[idx]),
      .idx        (idx),
      .best       (best),
      .best_idx   (best_idx),
`ifdef FC_SCORE_OUT_EN
      .second     (second),
      .second_c   (second_c),
`endif
      .best_c     (best_c),
      .best_idx_c (best_idx_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)  state_nx = SCAN;
         SCAN:    if (last_c)    state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath and handshake registers, all stepped by the current state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_CLASSES); i++) buffer[i] <= '0;
         best      <= '0;
         best_idx  <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         out_class <= '0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
`ifdef FC_SCORE_OUT_EN
         second     <= '0;
         out_score  <= '0;
         out_margin <= '0;
`endif
      end else begin
         in_ready <= (state_nx == IDLE);
         busy     <= (state_nx != IDLE);
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < int'(NUM_CLASSES); i++) buffer[i] <= in_vector[i];
                  best     <= in_vector[0];
                  best_idx <= '0;
                  idx      <= IDX_W'(1);
`ifdef FC_SCORE_OUT_EN
                  second   <= SCORE_MIN;
`endif
               end
            end
            SCAN: begin
               best     <= best_c;
               best_idx <= best_idx_c;
               idx      <= idx + IDX_W'(1);
`ifdef FC_SCORE_OUT_EN
               second   <= second_c;
`endif
               if (last_c) begin
                  out_valid <= 1'b1;
                  out_class <= best_idx_c;
`ifdef FC_SCORE_OUT_EN
                  out_score  <= best_c;
                  out_margin <= sat_margin(best_c, second_c);
`endif
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
